// File: rtl/qeciphy_rx_controller_pkg.sv
// qeciphy RX controller shared definitions.
// Frame geometry, controller states and FAW match.
package qeciphy_rx_controller_pkg;

  localparam int QECIPHY_CRC_GROUP_LEN = 7;

  localparam logic [63:0] QECIPHY_FAW =
    64'hF0C3_A55A_3CE1_96D2;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    CONFIRM,
    LOCKED,
    ERROR
  } qeciphy_rx_ctrl_state_t;

  function automatic int frame_len(
    input int groups
  );
    return QECIPHY_CRC_GROUP_LEN * groups + 1;
  endfunction

  function automatic logic is_faw(
    input logic [63:0] w
  );
    return w == QECIPHY_FAW;
  endfunction

endpackage

// File: rtl/qeciphy_rx_controller_if.sv
// qeciphy RX controller bus.
// Word stream, monitor status and controls.
interface qeciphy_rx_controller_if;

  logic        link_up_i;
  logic [63:0] tdata_i;
  logic        faw_error_i;
  logic        crc_error_i;
  logic        enable_o;
  logic        faw_boundary_o;
  logic        crc_boundary_o;
  logic        locked_o;
  logic [15:0] resync_count_o;

  modport master (
    output link_up_i,
    output tdata_i,
    output faw_error_i,
    output crc_error_i,
    input  enable_o,
    input  faw_boundary_o,
    input  crc_boundary_o,
    input  locked_o,
    input  resync_count_o
  );

  modport slave (
    input  link_up_i,
    input  tdata_i,
    input  faw_error_i,
    input  crc_error_i,
    output enable_o,
    output faw_boundary_o,
    output crc_boundary_o,
    output locked_o,
    output resync_count_o
  );

endinterface

// File: rtl/qeciphy_frame_position_counter.sv
// qeciphy frame position counter.
// Load-to-1, wrap, FAW/CRC word decode.
module qeciphy_frame_position_counter
  import qeciphy_rx_controller_pkg::*;
#(
  parameter  int GROUPS    = 9,
  localparam int FRAME_LEN = frame_len(GROUPS),
  localparam int PW        = $clog2(FRAME_LEN)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic          active_i,
  output logic [PW-1:0] pos_o,
  output logic          faw_boundary_o,
  output logic          crc_boundary_o
);

  localparam logic [PW-1:0] LAST =
    PW'(FRAME_LEN - 1);

  logic [PW-1:0] pos_q;

  // load marks the word after a FAW as pos 1
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pos_q <= '0;
    end else if (load_i) begin
      pos_q <= PW'(1);
    end else if (pos_q == LAST) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_q + PW'(1);
    end
  end

  // word-type strobes for the current word
  always_comb begin
    faw_boundary_o = active_i && (pos_q == '0);
    crc_boundary_o = active_i
      && (pos_q != '0)
      && ((32'(pos_q) % QECIPHY_CRC_GROUP_LEN)
          == 0);
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/qeciphy_rx_controller.sv
// qeciphy RX controller.
// FAW hunt, lock confirm, error holdoff.
module qeciphy_rx_controller
  import qeciphy_rx_controller_pkg::*;
#(
  parameter int GROUPS         = 9,
  parameter int CONFIRM_FRAMES = 3,
  parameter int HOLDOFF_CYCLES = 16
) (
  input logic                    clk_i,
  input logic                    rst_n_i,
  qeciphy_rx_controller_if.slave bus
);

  localparam int FRAME_LEN = frame_len(GROUPS);
  localparam int PW = $clog2(FRAME_LEN);

  localparam logic [PW-1:0] LAST =
    PW'(FRAME_LEN - 1);
  localparam logic [3:0] CNT_MIN =
    4'(CONFIRM_FRAMES);
  localparam logic [7:0] HOLD_INIT =
    8'(HOLDOFF_CYCLES - 1);

  qeciphy_rx_ctrl_state_t state_q;

  logic [3:0]    cnt_q;
  logic [7:0]    hold_q;
  logic [15:0]   resync_q;
  logic          enable_q;
  logic          locked_q;
  logic [PW-1:0] pos;
  logic          active;
  logic          load;
  logic          faw_hit;
  logic          err;
  logic          faw_b;
  logic          crc_b;

  assign faw_hit = is_faw(bus.tdata_i);
  assign err = bus.faw_error_i
             | bus.crc_error_i;
  assign active = state_q inside
    {CONFIRM, LOCKED};
  assign load = (state_q == HUNT)
             && bus.link_up_i
             && faw_hit;

  qeciphy_frame_position_counter #(
    .GROUPS(GROUPS)
  ) u_pos (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .load_i         (load),
    .active_i       (active),
    .pos_o          (pos),
    .faw_boundary_o (faw_b),
    .crc_boundary_o (crc_b)
  );

  // link drop beats errors; outputs follow state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      resync_q <= '0;
      enable_q <= 1'b0;
      locked_q <= 1'b0;
    end else if (!bus.link_up_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      enable_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= HUNT;
        end
        HUNT: begin
          if (faw_hit) begin
            state_q <= CONFIRM;
            cnt_q   <= 4'd1;
          end
        end
        CONFIRM: begin
          if (pos == '0) begin
            if (faw_hit) begin
              cnt_q <= cnt_q + 4'd1;
            end else begin
              state_q <= HUNT;
            end
          end else if (pos == LAST
                       && cnt_q >= CNT_MIN) begin
            state_q  <= LOCKED;
            enable_q <= 1'b1;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (err) begin
            state_q  <= ERROR;
            enable_q <= 1'b0;
            locked_q <= 1'b0;
            hold_q   <= HOLD_INIT;
            if (resync_q != 16'hFFFF) begin
              resync_q <= resync_q + 16'd1;
            end
          end
        end
        ERROR: begin
          if (hold_q == '0) begin
            state_q <= HUNT;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.enable_o       = enable_q;
  assign bus.locked_o       = locked_q;
  assign bus.resync_count_o = resync_q;
  assign bus.faw_boundary_o = faw_b;
  assign bus.crc_boundary_o = crc_b;

endmodule

// File: tb/tb_qeciphy_rx_controller.sv
// qeciphy RX controller bench.
// Random stream against a timeline model.
module tb_qeciphy_rx_controller;

  localparam logic [63:0] FAW =
    64'hF0C3_A55A_3CE1_96D2;
  localparam int FL   = 64;
  localparam int NONE = -1;
  localparam int INF  = 32'h7fff_ffff;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  qeciphy_rx_controller_if bus();

  qeciphy_rx_controller dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: cycle of the accepted hunted FAW,
  // first cycle hunting may start, resync count.
  int          found = NONE;
  int          seek  = INF;
  logic [15:0] m_cnt = 16'd0;

  int ph         = 10;
  int corrupt_at = NONE;

  function automatic bit m_locked();
    return found != NONE
        && (cyc - found) >= 3 * FL;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [15:0] obs,
    input logic [15:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%h want=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit a;
    int d;
    bit fb;
    bit cb;
    bit en;
    a  = found != NONE;
    d  = a ? (cyc - found) % FL : 0;
    fb = a && d == 0;
    cb = a && d != 0 && d % 7 == 0;
    en = m_locked();
    chk("faw_boundary",
        16'(bus.faw_boundary_o), 16'(fb));
    chk("crc_boundary",
        16'(bus.crc_boundary_o), 16'(cb));
    chk("enable", 16'(bus.enable_o), 16'(en));
    chk("locked", 16'(bus.locked_o), 16'(en));
    chk("resync_count",
        bus.resync_count_o, m_cnt);
  endtask

  task automatic cycle(
    input bit link,
    input bit ferr,
    input bit cerr
  );
    logic [63:0] w;
    bit          f;
    check_outputs();
    f = cyc >= ph && (cyc - ph) % FL == 0;
    w = {$urandom, $urandom};
    if (w == FAW) w = ~w;
    if (f) w = FAW;
    if (cyc == corrupt_at) w = FAW ^ 64'h1;
    bus.link_up_i   = link;
    bus.tdata_i     = w;
    bus.faw_error_i = ferr;
    bus.crc_error_i = cerr;
    if (!link || !rst_n) begin
      found = NONE;
      seek  = INF;
    end else if (found == NONE) begin
      if (seek == INF) begin
        seek = cyc + 1;
      end else if (cyc >= seek && w == FAW) begin
        found = cyc;
      end
    end else if (!m_locked()) begin
      if ((cyc - found) % FL == 0
          && w != FAW) begin
        found = NONE;
        seek  = cyc + 1;
      end
    end else if (ferr || cerr) begin
      found = NONE;
      seek  = cyc + 17;
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic noisy();
    bit fe;
    bit ce;
    fe = !m_locked()
      && $urandom_range(0, 7) == 0;
    ce = !m_locked()
      && $urandom_range(0, 7) == 0;
    cycle(1'b1, fe, ce);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) noisy();
  endtask

  task automatic run_until_locked(
    input int    budget,
    input string tag
  );
    int k;
    k = 0;
    while (!m_locked() && k < budget) begin
      noisy();
      k++;
    end
    n_assert++;
    assert (k < budget) else begin
      n_fail++;
      $error("FAIL %s got=timeout want=lock",
             tag);
    end
    chk(tag, 16'(bus.locked_o), 16'd1);
  endtask

  task automatic run_until_found(
    input int    budget,
    input string tag
  );
    int k;
    k = 0;
    while (found == NONE && k < budget) begin
      noisy();
      k++;
    end
    n_assert++;
    assert (k < budget) else begin
      n_fail++;
      $error("FAIL %s got=timeout want=faw",
             tag);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=end");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bus.link_up_i   = 1'b0;
    bus.tdata_i     = '0;
    bus.faw_error_i = 1'b0;
    bus.crc_error_i = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    cyc = 0;

    while (cyc < 201) noisy();
    chk("enable_201", 16'(bus.enable_o), 16'd0);
    noisy();
    chk("enable_202", 16'(bus.enable_o), 16'd1);
    chk("faw_202",
        16'(bus.faw_boundary_o), 16'd1);
    run(40);

    e = $urandom_range(0, 20);
    for (int i = 0; i < e; i++) noisy();
    e = cyc;
    cycle(1'b1, 1'b0, 1'b1);
    chk("enable_e1", 16'(bus.enable_o), 16'd0);
    chk("resync_1", bus.resync_count_o, 16'd1);
    while (cyc < e + 17) noisy();
    chk("hold_enable", 16'(bus.enable_o), 16'd0);
    run_until_locked(400, "relock_crc");
    run(5);

    cycle(1'b0, 1'b1, 1'b0);
    chk("drop_locked", 16'(bus.locked_o), 16'd0);
    chk("drop_resync",
        bus.resync_count_o, 16'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1);

    run_until_found(200, "find_faw");
    corrupt_at = found + 2 * FL;
    while (cyc <= corrupt_at) noisy();
    chk("bad_faw_hunt",
        16'(bus.faw_boundary_o), 16'd0);
    run_until_locked(500, "relock_bad_faw");
    corrupt_at = NONE;

    force dut.resync_q = 16'hFFFE;
    #1;
    release dut.resync_q;
    m_cnt = 16'hFFFE;
    chk("forced", bus.resync_count_o, 16'hFFFE);
    for (int n = 0; n < 3; n++) begin
      run($urandom_range(0, 10));
      cycle(1'b1, n[0], !n[0]);
      run_until_locked(400, "relock_sat");
    end
    chk("saturated",
        bus.resync_count_o, 16'hFFFF);

    run_until_found(200, "find_faw2");
    run(30);
    #3 rst_n = 1'b0;
    #1;
    found = NONE;
    seek  = INF;
    m_cnt = 16'd0;
    chk("rst_enable", 16'(bus.enable_o), 16'd0);
    chk("rst_faw",
        16'(bus.faw_boundary_o), 16'd0);
    chk("rst_crc",
        16'(bus.crc_boundary_o), 16'd0);
    chk("rst_resync",
        bus.resync_count_o, 16'd0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_until_locked(400, "relock_rst");
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/qeciphy_rx_controller.md
# qeciphy_rx_controller

Sequences the RX data monitor: hunts for the Frame Alignment Word (FAW) in the received 64-bit word stream and confirms frame lock. It generates the per-word `faw_boundary`/`crc_boundary` strobes and gates the monitor `enable`. On a monitor-reported FAW or CRC error it drops enable, holds off, and re-hunts. It sits between the transceiver/word-aligner output and the RX monitor, and sees the same `tdata` word in the same cycle as the monitor.

## Interface
- `GROUPS`, 9: CRC groups per frame; `FRAME_LEN = 7*GROUPS+1` words (default 64).
- `CONFIRM_FRAMES`, 3: consecutive FAWs at the expected position required for lock, including the hunted one; range 1..15.
- `HOLDOFF_CYCLES`, 16: cycles enable stays low after an error before re-hunting; range 1..255.
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `link_up_i` in 1: transceiver word-aligned and data valid.
- `tdata_i` in 64: received word, same word and same cycle as presented to the monitor.
- `faw_error_i` in 1: monitor sticky FAW error.
- `crc_error_i` in 1: monitor sticky CRC error.
- `enable_o` out 1: monitor enable.
- `faw_boundary_o` out 1: current `tdata_i` is frame position 0.
- `crc_boundary_o` out 1: current `tdata_i` is a CRC word.
- `locked_o` out 1: state is LOCKED.
- `resync_count_o` out 16: number of LOCKED→ERROR transitions, saturating.

## Operation
- Position counter `pos`, width `$clog2(FRAME_LEN)`, indexes the current `tdata_i` word.
  - Increments every cycle; wraps `FRAME_LEN-1`→0.
  - Valid only in CONFIRM and LOCKED.
- Frame layout: pos 0 = FAW; pos `7k` for k=1..GROUPS = CRC word; all other positions = data.
- Boundary strobes are combinational from the registered `pos` and state:
  - `faw_boundary_o = (CONFIRM|LOCKED) && pos==0`
  - `crc_boundary_o = (CONFIRM|LOCKED) && pos!=0 && pos%7==0`
- States:
  - IDLE: everything quiet. Go to HUNT when `link_up_i` is high.
  - HUNT: test `is_faw(tdata_i)` every cycle. On a match, go to CONFIRM with `pos`←1 and `cnt`←1.
  - CONFIRM: at pos 0, `is_faw` true increments `cnt`; false goes to HUNT. When `pos==FRAME_LEN-1` and `cnt>=CONFIRM_FRAMES`, go to LOCKED, so `enable_o` rises coincident with a pos-0 word.
  - LOCKED: `enable_o`=1. If `faw_error_i|crc_error_i`, go to ERROR and increment `resync_count_o` (saturating at 16'hFFFF).
  - ERROR: `enable_o`=0; the hold counter loads `HOLDOFF_CYCLES-1` on entry and decrements each cycle; at 0, go to HUNT. The monitor clears its sticky errors while disabled.
- `link_up_i` low in any state: go to IDLE next cycle. Hold counter and `cnt` clear; `resync_count_o` is kept.
- Error inputs are ignored outside LOCKED.
- `link_up_i` drop takes priority over an error in the same cycle: go to IDLE and do not count the resync.

## Timing
- Reset values: `enable_o`=0, `faw_boundary_o`=0, `crc_boundary_o`=0, `locked_o`=0, `resync_count_o`=0; state IDLE.
- All state, counter and enable transitions are registered, one cycle after the qualifying input.
- FAW found at cycle t: the boundary strobes are first valid at t+1 (pos 1). The first `faw_boundary_o` is at `t+FRAME_LEN`.
- With CONFIRM_FRAMES=3, `enable_o` rises at `t+3*FRAME_LEN`, i.e. on the 4th FAW (t+192 for defaults).
- Error sampled high at cycle e: `enable_o`=0 at e+1. HUNT state begins at `e+1+HOLDOFF_CYCLES`.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronous), except the combinational strobes, which follow the cleared state.

## Structure
- `qeciphy_pkg` additions:
  - `QECIPHY_CRC_GROUP_LEN = 7`
  - state enum `qeciphy_rx_ctrl_state_t` (IDLE, HUNT, CONFIRM, LOCKED, ERROR)
  - existing `is_faw()` is reused.
- One sub-module: `qeciphy_frame_position_counter`, which provides load-to-1, wrap, and the `faw_boundary`/`crc_boundary` decode. It is reusable by the TX framer.

## Test plan
- Reset, `link_up_i`=1, FAW at cycle 10 and every 64 words after it → `faw_boundary_o` at 74, 138, 202; `crc_boundary_o` at 17, 24, …, 73; `enable_o`/`locked_o` rise at 202.
- Same stimulus with a corrupted FAW at cycle 138 → return to HUNT at 139; `enable_o` never rises; the next valid FAW restarts confirm.
- Locked, pulse `crc_error_i` at cycle e → `enable_o`=0 at e+1; `resync_count_o`=1; HUNT at e+17; relock after 3 frames.
- Locked, `faw_error_i` and `link_up_i`=0 in the same cycle → IDLE; `resync_count_o` unchanged.
- Force `resync_count_o` to 16'hFFFE, inject 3 errors → count is 16'hFFFF and stays there.
- Assert `rst_n_i` low mid-CONFIRM between clock edges → all outputs 0 before the next edge; HUNT resumes only after release with `link_up_i`=1.
